pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage that consumes the jump-control outputs (`jmp_loc`, `pc_mux_sel`) and produces the `current_address`, `op` and `jmp_address_pm` that jump control evaluates.
- Owns the PC and issues reads to a synchronous program memory with one-cycle read latency.
- Holds the fetched instruction in an instruction register (IR).
- Squashes wrong-path fetches when a jump is taken.
- Sits between program memory and the jump-control / decode logic of the MIPS-style core.

## Interface
- `RESET_VECTOR`, default 16'h0000: PC value after reset.
- `IW`, default 24: instruction width; `op` = `[IW-1:IW-6]`, address field = `[15:0]`.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low (0 = reset, sampled on `clk` rising edge).
- `pc_mux_sel`  in  1: taken jump/interrupt from jump control; PC loads `jmp_loc`.
- `jmp_loc`  in  16: jump target.
- `stall`  in  1: downstream not ready; IR and PC hold.
- `pm_addr`  out  16: program-memory read address.
- `pm_rd_en`  out  1: program-memory read strobe.
- `pm_rdata`  in  IW: read data, valid the cycle after `pm_addr`/`pm_rd_en`.
- `current_address`  out  16: address of the instruction in IR.
- `op`  out  6: IR opcode field.
- `jmp_address_pm`  out  16: IR address field.
- `ir_valid`  out  1: IR holds a live instruction.

## Operation
- Registers:
  - `pc`: next address to issue.
  - `f_pc`/`f_valid`: read in flight.
  - `ir`/`ir_pc`/`ir_valid`.
- Reset: `pc`=`RESET_VECTOR`; `f_valid`=0; `ir`=0; `ir_pc`=0; `ir_valid`=0. Outputs during reset: `pm_rd_en`=0, `op`=0, `jmp_address_pm`=0, `current_address`=0.
- `pm_addr` = `pc` (combinational); `pm_rd_en` = `!stall` outside reset.
- Normal cycle (`stall`=0, `pc_mux_sel`=0):
  - `f_pc`<=`pc`, `f_valid`<=1.
  - If `f_valid`: `ir`<=`pm_rdata`, `ir_pc`<=`f_pc`. `ir_valid`<=`f_valid`.
  - `pc`<=`pc`+1, modulo 2^16: 16'hFFFF wraps to 16'h0000 with no flag.
- Flush (`pc_mux_sel`=1):
  - `pc`<=`jmp_loc`; `f_valid`<=0; `ir_valid`<=0. IR contents are retained but dead.
  - Flush takes priority over `stall`.
  - Flush in the same cycle as reset: reset wins.
- Stall (`stall`=1, no flush):
  - `ir`, `ir_pc`, `ir_valid` hold.
  - The in-flight word is handled per Configuration.
- Reset deasserted mid-stall or mid-flush: the state is fully reinitialised; fetch restarts at `RESET_VECTOR`.

## Timing
- Fetch-to-IR latency is 2 cycles: `pm_addr`=A in cycle t; `pm_rdata` is valid in t+1; `ir_valid`=1 with `current_address`=A in t+2.
- Taken-jump penalty: `pc_mux_sel` in cycle t gives `pm_addr`=`jmp_loc` in t+1 and the target in IR in t+3.
  - `ir_valid`=0 in t+1 and t+2.
- Steady state: one instruction per cycle.
- After the first instruction is valid, `current_address` increments by 1 each unstalled cycle.

## Configuration
- `FETCH_SKID_EN` defined: on the first stall cycle with `f_valid`=1, `pm_rdata` and `f_pc` are captured into the skid buffer.
  - On the first unstalled cycle, IR loads from the skid buffer.
  - Fetch resumes at `pc` with no bubble.
  - A flush clears the skid buffer.
- `FETCH_SKID_EN` undefined: on the first stall cycle with `f_valid`=1, `pc`<=`f_pc` (rewind) and `f_valid`<=0.
  - After the stall, the word is refetched: one bubble (`ir_valid`=0 for one cycle).

## Structure
- Package `fetch_pkg`: `PC_W`=16, `IW`=24, `OP_W`=6, op/address field positions, default `RESET_VECTOR`, instruction struct typedef.
- Sub-module `fetch_skid_buf`: single-entry skid register (data, address, valid), instantiated only under `FETCH_SKID_EN`.
- The top level contains the PC, the in-flight tracking and the IR.

## Test plan
- Reset low for 1 cycle, memory returns `{op, addr}` = address → first `ir_valid` 2 cycles after reset release; `current_address` 0,1,2,3… each cycle.
- `pc_mux_sel`=1, `jmp_loc`=16'h0008 at `current_address`=3 → `pm_addr`=8 the next cycle; `ir_valid` low 2 cycles; then `current_address`=8, `op`=`pm_rdata[23:18]`.
- `stall` for 3 cycles at `current_address`=5 → IR holds 5.
  - With `FETCH_SKID_EN`: 6 appears on the first unstalled cycle.
  - Without: one bubble, then 6.
- `pc_mux_sel` and `stall` together, `jmp_loc`=16'h0020 → flush wins; next `pm_addr`=16'h0020; skid buffer empty.
- `RESET_VECTOR`=16'hFFFE, no stall → `current_address` FFFE, FFFF, 0000.
- `reset` pulsed low during a stall with the skid buffer full → all outputs 0, `ir_valid`=0; fetch restarts at `RESET_VECTOR`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, instruction-field positions and the instruction layout
// used by the fetch stage and its skid buffer.
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int IW      = 24;
  localparam int OP_W    = 6;
  localparam int OP_HI   = IW - 1;
  localparam int OP_LO   = IW - OP_W;
  localparam int ADDR_HI = PC_W - 1;
  localparam int ADDR_LO = 0;

  localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 16'h0000;

  typedef struct packed {
    logic [OP_W-1:0]         op;
    logic [IW-OP_W-PC_W-1:0] rsvd;
    logic [PC_W-1:0]         addr;
  } instr_t;

  // The PC space is a plain 16-bit ring: FFFF rolls over to 0000.
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry skid register holding one fetched word and its address
// while the fetch stage is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int DW = IW,
  parameter int AW = PC_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          clear,
  input  logic          pop,
  input  logic [DW-1:0] load_data,
  input  logic [AW-1:0] load_addr,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [AW-1:0] addr
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the payload is qualified by valid, so it needs no reset and can map
  // onto plain (non-resettable) flops.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= load_data;
      addr <= load_addr;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC, one-cycle-latency program-memory fetch and instruction register.
// Build option FETCH_SKID_EN: park a stalled in-flight word instead of refetching it.
module pc_fetch_unit #(
  parameter logic [fetch_pkg::PC_W-1:0] RESET_VECTOR = fetch_pkg::DEFAULT_RESET_VECTOR,
  parameter int                         IW           = fetch_pkg::IW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pc_mux_sel,
  input  logic [fetch_pkg::PC_W-1:0]  jmp_loc,
  input  logic                        stall,
  output logic [fetch_pkg::PC_W-1:0]  pm_addr,
  output logic                        pm_rd_en,
  input  logic [IW-1:0]               pm_rdata,
  output logic [fetch_pkg::PC_W-1:0]  current_address,
  output logic [fetch_pkg::OP_W-1:0]  op,
  output logic [fetch_pkg::PC_W-1:0]  jmp_address_pm,
  output logic                        ir_valid
);
  import fetch_pkg::*;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] f_pc_q, f_pc_d;
  logic            f_valid_q, f_valid_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [PC_W-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic            unused_ir_rsvd;

`ifdef FETCH_SKID_EN
  logic            skid_load;
  logic            skid_pop;
  logic            skid_valid;
  logic [IW-1:0]   skid_data;
  logic [PC_W-1:0] skid_addr;

  fetch_skid_buf #(
    .DW (IW),
    .AW (PC_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (pc_mux_sel),
    .pop       (skid_pop),
    .load_data (pm_rdata),
    .load_addr (f_pc_q),
    .valid     (skid_valid),
    .data      (skid_data),
    .addr      (skid_addr)
  );
`endif

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    pc_d       = pc_q;
    f_pc_d     = f_pc_q;
    f_valid_d  = f_valid_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
`ifdef FETCH_SKID_EN
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
`endif

    if (pc_mux_sel) begin
      // Taken jump squashes everything younger than the IR; IR data stays but is dead.
      pc_d       = jmp_loc;
      f_valid_d  = 1'b0;
      ir_valid_d = 1'b0;
    end else if (stall) begin
      if (f_valid_q) begin
`ifdef FETCH_SKID_EN
        skid_load = 1'b1;
`else
        pc_d      = f_pc_q;
`endif
        f_valid_d = 1'b0;
      end
    end else begin
      f_pc_d    = pc_q;
      f_valid_d = 1'b1;
      pc_d      = pc_incr(pc_q);
`ifdef FETCH_SKID_EN
      if (skid_valid) begin
        ir_d       = skid_data;
        ir_pc_d    = skid_addr;
        ir_valid_d = 1'b1;
        skid_pop   = 1'b1;
      end else
`endif
      begin
        if (f_valid_q) begin
          ir_d    = pm_rdata;
          ir_pc_d = f_pc_q;
        end
        ir_valid_d = f_valid_q;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge values no matter how blocks are ordered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_VECTOR;
      f_pc_q     <= '0;
      f_valid_q  <= 1'b0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      f_pc_q     <= f_pc_d;
      f_valid_q  <= f_valid_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Outputs read as zero for the whole reset cycle, not only after the edge.
  assign pm_addr         = pc_q;
  assign pm_rd_en        = reset && !stall;
  assign current_address = reset ? ir_pc_q : '0;
  assign op              = reset ? ir_q[IW-1 -: OP_W] : '0;
  assign jmp_address_pm  = reset ? ir_q[PC_W-1:0] : '0;
  assign ir_valid        = reset && ir_valid_q;

  assign unused_ir_rsvd  = ^ir_q[IW-OP_W-1:PC_W];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: directed timing scenarios, then random
// stall/jump/reset traffic checked against a program-order reference model.
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  localparam logic [15:0] RV_A = 16'h0000;
  localparam logic [15:0] RV_B = 16'hFFFE;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        stall      = 1'b0;
  logic        pc_mux_sel = 1'b0;
  logic [15:0] jmp_loc    = '0;
  logic [15:0] pm_addr, current_address, jmp_address_pm;
  logic        pm_rd_en, ir_valid;
  logic [5:0]  op;
  logic [23:0] pm_rdata   = '0;

  logic        stall_b    = 1'b0;
  logic        sel_b      = 1'b0;
  logic [15:0] jmp_loc_b  = '0;
  logic [15:0] pm_addr_b, cur_b, jmp_addr_b;
  logic        pm_rd_en_b, ir_valid_b;
  logic [5:0]  op_b;
  logic [23:0] pm_rdata_b = '0;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          consumed = 0;
  logic [15:0] exp_addr = RV_A;
  logic [15:0] redirect_q[$];

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_VECTOR(RV_A), .IW(24)) dut (
    .clk (clk), .reset (reset), .pc_mux_sel (pc_mux_sel), .jmp_loc (jmp_loc),
    .stall (stall), .pm_addr (pm_addr), .pm_rd_en (pm_rd_en), .pm_rdata (pm_rdata),
    .current_address (current_address), .op (op), .jmp_address_pm (jmp_address_pm),
    .ir_valid (ir_valid)
  );

  pc_fetch_unit #(.RESET_VECTOR(RV_B), .IW(24)) dut_b (
    .clk (clk), .reset (reset), .pc_mux_sel (sel_b), .jmp_loc (jmp_loc_b),
    .stall (stall_b), .pm_addr (pm_addr_b), .pm_rd_en (pm_rd_en_b), .pm_rdata (pm_rdata_b),
    .current_address (cur_b), .op (op_b), .jmp_address_pm (jmp_addr_b),
    .ir_valid (ir_valid_b)
  );

  function automatic logic [5:0] op_of(input logic [15:0] a);
    return a[5:0] ^ a[15:10];
  endfunction

  function automatic logic [23:0] mem_word(input logic [15:0] a);
    instr_t w;
    w.op   = op_of(a);
    w.rsvd = a[7:6];
    w.addr = a;
    return w;
  endfunction

  // Synchronous program memories, one-cycle read latency.
  always @(posedge clk) begin
    if (pm_rd_en)   pm_rdata   <= mem_word(pm_addr);
    if (pm_rd_en_b) pm_rdata_b <= mem_word(pm_addr_b);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [15:0] j);
    @(posedge clk);
    #1;
    reset      = r;
    stall      = s;
    pc_mux_sel = f;
    jmp_loc    = j;
    if (f && r) redirect_q.push_back(j);
    @(negedge clk);
  endtask

  // Monitor: instructions retire in program order (sequential, restarting at
  // the jump target or reset vector); each retirement is compared to the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_outputs", 64'({pm_rd_en, op, jmp_address_pm, current_address, ir_valid}), 64'(0));
      exp_addr = RV_A;
    end else begin
      if (ir_valid && !stall) begin
        check("stream_addr", 64'(current_address), 64'(exp_addr));
        check("stream_fields", 64'({op, jmp_address_pm}), 64'({op_of(exp_addr), exp_addr}));
        consumed++;
      end
      if (pc_mux_sel) begin
        if (redirect_q.size() == 0) begin
          n_checks++;
          $display("FAIL redirect_queue: got empty expected pending target (t=%0t)", $time);
        end else begin
          exp_addr = redirect_q.pop_front();
        end
      end else if (ir_valid && !stall) begin
        exp_addr = exp_addr + 16'd1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] eb;

    // Reset, pipeline fill, then a taken jump to 0x0008 at address 3.
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("reset_pm_addr", 64'(pm_addr), 64'(RV_A));
    check("reset_ir_valid", 64'(ir_valid), 64'(0));
    check("reset_rd_en", 64'(pm_rd_en), 64'(1));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("fill_ir_valid", 64'(ir_valid), 64'(0));
    check("fill_pm_addr", 64'(pm_addr), 64'(16'h0001));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, (i == 3), 16'h0008);
      check("seq_valid", 64'(ir_valid), 64'(1));
      check("seq_addr", 64'(current_address), 64'(i));
      eb = RV_B + 16'(i);
      check("wrap_addr", 64'({ir_valid_b, cur_b}), 64'({1'b1, eb}));
      check("wrap_op", 64'(op_b), 64'(op_of(eb)));
    end
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("jump_pm_addr", 64'(pm_addr), 64'(16'h0008));
    check("jump_bubble1", 64'(ir_valid), 64'(0));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("jump_bubble2", 64'(ir_valid), 64'(0));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("jump_target", 64'({ir_valid, current_address}), 64'({1'b1, 16'h0008}));
    check("jump_op", 64'(op), 64'(op_of(16'h0008)));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("post_jump_seq", 64'(current_address), 64'(16'h0009));

    // Three-cycle stall with address 10 in the IR.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      check("stall_hold", 64'({ir_valid, current_address}), 64'({1'b1, 16'h000A}));
    end
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("unstall_ir", 64'({ir_valid, current_address}), 64'({1'b1, 16'h000A}));
`ifdef FETCH_SKID_EN
    check("unstall_pm_addr", 64'(pm_addr), 64'(16'h000C));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("skid_next", 64'({ir_valid, current_address}), 64'({1'b1, 16'h000B}));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("skid_next2", 64'({ir_valid, current_address}), 64'({1'b1, 16'h000C}));
`else
    check("unstall_pm_addr", 64'(pm_addr), 64'(16'h000B));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("refetch_bubble", 64'(ir_valid), 64'(0));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("refetch_next", 64'({ir_valid, current_address}), 64'({1'b1, 16'h000B}));
`endif

    // Jump arriving while stalled with an in-flight word parked.
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h0020);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("flush_stall_pm_addr", 64'(pm_addr), 64'(16'h0020));
    check("flush_stall_bubble1", 64'(ir_valid), 64'(0));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("flush_stall_bubble2", 64'(ir_valid), 64'(0));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("flush_stall_target", 64'({ir_valid, current_address}), 64'({1'b1, 16'h0020}));

    // Reset pulse during a stall with a parked word.
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("rst_stall_pm_addr", 64'(pm_addr), 64'(RV_A));
    check("rst_stall_ir", 64'({ir_valid, current_address}), 64'(0));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("rst_stall_bubble", 64'(ir_valid), 64'(0));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check("rst_stall_restart", 64'({ir_valid, current_address}), 64'({1'b1, RV_A}));

    // Random traffic; targets often land just below FFFF to cross the wrap.
    for (int c = 0; c < 3000; c++) begin
      logic        r, s, f;
      logic [15:0] j;
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 11) == 0);
      j = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
      step(r, s, f, j);
    end
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 16'h0000);

    check("throughput_floor", 64'(consumed >= 900), 64'(1));
    check("redirects_drained", 64'(redirect_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
